fir_controller: RTL and testbench

Control FSM for the 4-tap FIR sample datapath. Sequences coefficient loading and per-sample shift/multiply/accumulate micro-ops onto the 16-entry register-file datapath. Drives the 1000-sample counter stage with `cnt_up` and `clear`, and consumes its `one_k_samples` rollover flag to produce a frame-done pulse.

---
 rtl/fir_controller.sv | 135 +++++++++++++
 tb/tb_fir_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_controller.sv
// Control FSM for the 4-tap FIR sample datapath: coefficient loading, per-sample
// shift/multiply/accumulate micro-op sequencing and a frame-done pulse.
module fir_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       dr,
    input  logic       lc,
    input  logic       overflow,
    input  logic       one_k_samples,
    output logic       cnt_up,
    output logic       clear,
    output logic       modwait,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       err,
    output logic       frame_done
);

    localparam logic [4:0] S_IDLE  = 5'd0;
    localparam logic [4:0] S_STORE = 5'd1;
    localparam logic [4:0] S_SORT1 = 5'd2;
    localparam logic [4:0] S_SORT2 = 5'd3;
    localparam logic [4:0] S_SORT3 = 5'd4;
    localparam logic [4:0] S_SORT4 = 5'd5;
    localparam logic [4:0] S_MUL1  = 5'd6;
    localparam logic [4:0] S_CPY1  = 5'd7;
    localparam logic [4:0] S_MUL2  = 5'd8;
    localparam logic [4:0] S_SUB2  = 5'd9;
    localparam logic [4:0] S_MUL3  = 5'd10;
    localparam logic [4:0] S_ADD3  = 5'd11;
    localparam logic [4:0] S_MUL4  = 5'd12;
    localparam logic [4:0] S_SUB4  = 5'd13;
    localparam logic [4:0] S_LDF0  = 5'd14;
    localparam logic [4:0] S_WF1   = 5'd15;
    localparam logic [4:0] S_LDF1  = 5'd16;
    localparam logic [4:0] S_WF2   = 5'd17;
    localparam logic [4:0] S_LDF2  = 5'd18;
    localparam logic [4:0] S_WF3   = 5'd19;
    localparam logic [4:0] S_LDF3  = 5'd20;
    localparam logic [4:0] S_EIDLE = 5'd21;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_COPY  = 3'd1;
    localparam logic [2:0] OP_LOADS = 3'd2;
    localparam logic [2:0] OP_LOADC = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;

    logic [4:0] state_q, state_d;
    logic       onek_q;
    logic       frame_done_q, frame_done_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_EIDLE: begin
                if (dr)      state_d = S_STORE;
                else if (lc) state_d = S_LDF0;
            end
            S_STORE: state_d = dr ? S_SORT1 : S_EIDLE;
            S_SORT1: state_d = S_SORT2;
            S_SORT2: state_d = S_SORT3;
            S_SORT3: state_d = S_SORT4;
            S_SORT4: state_d = S_MUL1;
            S_MUL1:  state_d = S_CPY1;
            S_CPY1:  state_d = S_MUL2;
            S_MUL2:  state_d = S_SUB2;
            S_SUB2:  state_d = overflow ? S_EIDLE : S_MUL3;
            S_MUL3:  state_d = S_ADD3;
            S_ADD3:  state_d = overflow ? S_EIDLE : S_MUL4;
            S_MUL4:  state_d = S_SUB4;
            S_SUB4:  state_d = overflow ? S_EIDLE : S_IDLE;
            S_LDF0:  state_d = S_WF1;
            S_WF1:   if (lc) state_d = S_LDF1;
            S_LDF1:  state_d = S_WF2;
            S_WF2:   if (lc) state_d = S_LDF2;
            S_LDF2:  state_d = S_WF3;
            S_WF3:   if (lc) state_d = S_LDF3;
            S_LDF3:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore decode: every datapath control field depends on the state alone.
    always_comb begin
        op      = OP_NOP;
        src1    = 4'd0;
        src2    = 4'd0;
        dest    = 4'd0;
        cnt_up  = 1'b0;
        clear   = 1'b0;
        modwait = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_STORE: begin op = OP_LOADS; dest = 4'd5; cnt_up = 1'b1; modwait = 1'b1; end
            S_SORT1: begin op = OP_COPY; src1 = 4'd2; dest = 4'd1; modwait = 1'b1; end
            S_SORT2: begin op = OP_COPY; src1 = 4'd3; dest = 4'd2; modwait = 1'b1; end
            S_SORT3: begin op = OP_COPY; src1 = 4'd4; dest = 4'd3; modwait = 1'b1; end
            S_SORT4: begin op = OP_COPY; src1 = 4'd5; dest = 4'd4; modwait = 1'b1; end
            S_MUL1:  begin op = OP_MUL; src1 = 4'd1; src2 = 4'd6; dest = 4'd10; modwait = 1'b1; end
            S_CPY1:  begin op = OP_COPY; src1 = 4'd10; dest = 4'd0; modwait = 1'b1; end
            S_MUL2:  begin op = OP_MUL; src1 = 4'd2; src2 = 4'd7; dest = 4'd10; modwait = 1'b1; end
            S_SUB2:  begin op = OP_SUB; src1 = 4'd0; src2 = 4'd10; dest = 4'd0; modwait = 1'b1; end
            S_MUL3:  begin op = OP_MUL; src1 = 4'd3; src2 = 4'd8; dest = 4'd10; modwait = 1'b1; end
            S_ADD3:  begin op = OP_ADD; src1 = 4'd0; src2 = 4'd10; dest = 4'd0; modwait = 1'b1; end
            S_MUL4:  begin op = OP_MUL; src1 = 4'd4; src2 = 4'd9; dest = 4'd10; modwait = 1'b1; end
            S_SUB4:  begin op = OP_SUB; src1 = 4'd0; src2 = 4'd10; dest = 4'd0; modwait = 1'b1; end
            S_LDF0:  begin op = OP_LOADC; dest = 4'd6; clear = 1'b1; modwait = 1'b1; end
            S_LDF1:  begin op = OP_LOADC; dest = 4'd7; modwait = 1'b1; end
            S_LDF2:  begin op = OP_LOADC; dest = 4'd8; modwait = 1'b1; end
            S_LDF3:  begin op = OP_LOADC; dest = 4'd9; modwait = 1'b1; end
            S_EIDLE: err = 1'b1;
            default: ;
        endcase
    end

    assign frame_done_d = one_k_samples & ~onek_q;
    assign frame_done   = frame_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            onek_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            onek_q       <= one_k_samples;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_fir_controller.sv
// Self-checking bench for fir_controller: directed scenarios plus randomized
// traffic compared every cycle against a table-driven sequence model.
module tb_fir_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dr = 1'b0, lc = 1'b0, overflow = 1'b0, one_k_samples = 1'b0;
    logic       cnt_up, clear, modwait, err, frame_done;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;

    int n_checks = 0;
    int n_fail   = 0;

    fir_controller dut (
        .clk(clk), .rst(rst), .dr(dr), .lc(lc), .overflow(overflow),
        .one_k_samples(one_k_samples), .cnt_up(cnt_up), .clear(clear),
        .modwait(modwait), .op(op), .src1(src1), .src2(src2), .dest(dest),
        .err(err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // The per-sample micro-program, one entry per cycle after dr is accepted.
    int seq_op [13] = '{2, 1, 1, 1, 1, 6, 1, 6, 5, 6, 4, 6, 5};
    int seq_s1 [13] = '{0, 2, 3, 4, 5, 1, 10, 2, 0, 3, 0, 4, 0};
    int seq_s2 [13] = '{0, 0, 0, 0, 0, 6, 0, 7, 10, 8, 10, 9, 10};
    int seq_dst[13] = '{5, 1, 2, 3, 4, 10, 0, 10, 0, 10, 0, 10, 0};

    localparam int M_IDLE = 0, M_ERR = 1, M_SEQ = 2, M_LOAD = 3, M_WAIT = 4;
    int m_mode, m_idx;
    bit m_prev, m_fd;

    task automatic model_reset();
        m_mode = M_IDLE; m_idx = 0; m_prev = 1'b0; m_fd = 1'b0;
    endtask

    task automatic model_step(input bit d, input bit l, input bit o, input bit k);
        m_fd   = k & ~m_prev;
        m_prev = k;
        case (m_mode)
            M_IDLE, M_ERR: begin
                if (d)      begin m_mode = M_SEQ;  m_idx = 0; end
                else if (l) begin m_mode = M_LOAD; m_idx = 0; end
            end
            M_SEQ: begin
                if (m_idx == 0 && !d) m_mode = M_ERR;
                else if (o && (seq_op[m_idx] == 4 || seq_op[m_idx] == 5)) m_mode = M_ERR;
                else if (m_idx == 12) m_mode = M_IDLE;
                else m_idx++;
            end
            M_LOAD: begin
                if (m_idx == 3) m_mode = M_IDLE;
                else begin m_mode = M_WAIT; m_idx++; end
            end
            M_WAIT: if (l) m_mode = M_LOAD;
            default: m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [19:0] model_out();
        logic [2:0] o = 0; logic [3:0] a = 0, b = 0, t = 0;
        logic cu = 0, cl = 0, mw = 0, er = 0;
        case (m_mode)
            M_ERR: er = 1;
            M_SEQ: begin
                o = 3'(seq_op[m_idx]); a = 4'(seq_s1[m_idx]); b = 4'(seq_s2[m_idx]);
                t = 4'(seq_dst[m_idx]); mw = 1; cu = (m_idx == 0);
            end
            M_LOAD: begin o = 3; t = 4'(6 + m_idx); cl = (m_idx == 0); mw = 1; end
            default: ;
        endcase
        return {o, a, b, t, cu, cl, mw, er, m_fd};
    endfunction

    task automatic tick(input bit d, input bit l, input bit o, input bit k);
        dr = d; lc = l; overflow = o; one_k_samples = k;
        @(posedge clk);
        model_step(d, l, o, k);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        n_checks++;
        if ({op, src1, src2, dest, cnt_up, clear, modwait, err, frame_done} !== 20'd0) begin
            n_fail++; $display("FAIL reset_state outputs=%h expected 0", {op, src1, src2, dest, cnt_up, clear, modwait, err, frame_done});
        end
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
        n_checks++;
        if (op !== 3'd6 || src2 !== 4'd7) begin
            n_fail++; $display("FAIL reset_reach_mul2 op=%0d src2=%0d expected 6/7", op, src2);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({op, src1, src2, dest, cnt_up, clear, modwait, err, frame_done} !== 20'd0) begin
            n_fail++; $display("FAIL reset_async outputs=%h expected 0", {op, src1, src2, dest, cnt_up, clear, modwait, err, frame_done});
        end
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        tick(0, 0, 0, 0);
        n_checks++;
        if (op !== 3'd0 || modwait !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle op=%0d modwait=%b err=%b expected 0/0/0", op, modwait, err);
        end
    endtask

    task automatic test_coef_load();
        for (int k = 0; k < 4; k++) begin
            tick(0, 1, 0, 0);
            n_checks++;
            if (op !== 3'd3 || dest !== 4'(6 + k) || clear !== (k == 0) || modwait !== 1'b1) begin
                n_fail++; $display("FAIL coef_load%0d op=%0d dest=%0d clear=%b modwait=%b expected 3/%0d/%b/1",
                                   k, op, dest, clear, modwait, 6 + k, k == 0);
            end
            if (k < 3) begin
                for (int g = 0; g < 3; g++) begin
                    tick(1, 0, 0, 0);
                    n_checks++;
                    if (modwait !== 1'b0 || op !== 3'd0 || clear !== 1'b0) begin
                        n_fail++; $display("FAIL coef_gap%0d modwait=%b op=%0d clear=%b expected 0/0/0", k, modwait, op, clear);
                    end
                end
            end
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (op !== 3'd0 || modwait !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL coef_return op=%0d modwait=%b err=%b expected idle", op, modwait, err);
        end
    endtask

    task automatic test_normal_sample();
        int cnt_pulses = 0;
        for (int i = 0; i < 13; i++) begin
            tick(i < 2, 0, 0, 0);
            cnt_pulses += int'(cnt_up);
            n_checks++;
            if (op !== 3'(seq_op[i]) || dest !== 4'(seq_dst[i]) || src1 !== 4'(seq_s1[i]) ||
                src2 !== 4'(seq_s2[i]) || modwait !== 1'b1) begin
                n_fail++; $display("FAIL sample_step%0d op=%0d s1=%0d s2=%0d dest=%0d mw=%b expected %0d/%0d/%0d/%0d/1",
                                   i, op, src1, src2, dest, modwait, seq_op[i], seq_s1[i], seq_s2[i], seq_dst[i]);
            end
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (cnt_pulses != 1 || modwait !== 1'b0 || op !== 3'd0) begin
            n_fail++; $display("FAIL sample_end cnt_up_pulses=%0d modwait=%b op=%0d expected 1/0/0", cnt_pulses, modwait, op);
        end
    endtask

    task automatic test_dr_glitch();
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        n_checks++;
        if (err !== 1'b1 || op !== 3'd0 || modwait !== 1'b0) begin
            n_fail++; $display("FAIL glitch_err err=%b op=%0d modwait=%b expected 1/0/0", err, op, modwait);
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL glitch_hold err=%b expected 1", err);
        end
        tick(1, 0, 0, 0);
        n_checks++;
        if (err !== 1'b0 || op !== 3'd2 || cnt_up !== 1'b1) begin
            n_fail++; $display("FAIL glitch_restart err=%b op=%0d cnt_up=%b expected 0/2/1", err, op, cnt_up);
        end
        tick(1, 0, 0, 0);
        for (int i = 2; i < 13; i++) tick(0, 0, 0, 0);
        n_checks++;
        if (op !== 3'd5 || err !== 1'b0) begin
            n_fail++; $display("FAIL glitch_last op=%0d err=%b expected 5/0", op, err);
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (modwait !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL glitch_done modwait=%b err=%b expected 0/0", modwait, err);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 11; i++) tick(i < 2, 0, 0, 0);
        n_checks++;
        if (op !== 3'd4) begin
            n_fail++; $display("FAIL ovf_at_add3 op=%0d expected 4", op);
        end
        tick(0, 0, 1, 0);
        n_checks++;
        if (err !== 1'b1 || op !== 3'd0 || modwait !== 1'b0) begin
            n_fail++; $display("FAIL ovf_err err=%b op=%0d modwait=%b expected 1/0/0", err, op, modwait);
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (err !== 1'b1 || op !== 3'd0) begin
            n_fail++; $display("FAIL ovf_no_tail err=%b op=%0d expected 1/0", err, op);
        end
    endtask

    task automatic test_frame();
        int highs = 0;
        tick(0, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            tick(0, 0, 0, j < 5);
            highs += int'(frame_done);
            n_checks++;
            if (frame_done !== (j == 0)) begin
                n_fail++; $display("FAIL frame_cycle%0d frame_done=%b expected %b", j, frame_done, j == 0);
            end
        end
        n_checks++;
        if (highs != 1) begin
            n_fail++; $display("FAIL frame_count high_cycles=%0d expected 1", highs);
        end
    endtask

    task automatic test_random();
        logic [19:0] got, exp;
        bit k = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) k = ~k;
            tick($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(15) == 0, k);
            got = {op, src1, src2, dest, cnt_up, clear, modwait, err, frame_done};
            exp = model_out();
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL random_cycle%0d outputs=%h expected %h", c, got, exp);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_coef_load();
        test_normal_sample();
        test_dr_glitch();
        test_overflow();
        test_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
